pip_reader: RTL and testbench

PIP_READER -- requirements
Module: pip_reader

---
 rtl/adc_pkg.sv | 18 +
 rtl/byte_tx_reg.sv | 35 +++
 rtl/pip_reader.sv | 121 ++++++++++++
 tb/tb_pip_reader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the sample-frame reader: FSM encoding, default
// frame header byte and checksum width.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_WAIT,
    ST_HI,
    ST_LO,
    ST_CSUM
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         CSUM_W       = 8;

endpackage

// File: rtl/byte_tx_reg.sv
// Byte holding register with a valid/ready handshake. A load always wins
// over a transfer, so a new byte can follow the old one with no bubble.
module byte_tx_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_xfer
);

  logic [7:0] r_data;
  logic       r_valid;

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_xfer  = r_valid & i_ready;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (o_xfer) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pip_reader.sv
// Pops 16-bit samples from a FIFO and streams them as framed bytes:
// SYNC, samples MSB-first, then an XOR checksum of the sample bytes.
module pip_reader
  import adc_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter int         FRAME_LEN  = 256,
  parameter logic [7:0] SYNC       = SYNC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] q,
  output logic                  rd,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_sample;
  logic [15:0]           r_cnt;
  logic [CSUM_W-1:0]     r_csum;
  logic [15:0]           r_frame_cnt;

  logic       w_xfer;
  logic       w_load;
  logic [7:0] w_load_data;
  logic       w_last;

  assign w_last    = (r_cnt == LAST_IDX);
  assign rd        = (r_state == ST_FETCH) && !empty;
  assign busy      = (r_state != ST_IDLE);
  assign frame_cnt = r_frame_cnt;

  // Each byte is loaded on the edge that enters the state presenting it.
  // NOTE: defaults first so no path through the case leaves a latch.
  always_comb begin
    w_load      = 1'b0;
    w_load_data = 8'h00;
    unique case (r_state)
      ST_IDLE: if (en) begin
        w_load      = 1'b1;
        w_load_data = SYNC;
      end
      ST_WAIT: begin
        w_load      = 1'b1;
        w_load_data = q[15:8];
      end
      ST_HI: if (w_xfer) begin
        w_load      = 1'b1;
        w_load_data = r_sample[7:0];
      end
      ST_LO: if (w_xfer && w_last) begin
        w_load      = 1'b1;
        w_load_data = r_csum ^ r_sample[7:0];
      end
      ST_CSUM: if (w_xfer && en) begin
        w_load      = 1'b1;
        w_load_data = SYNC;
      end
      default: ;
    endcase
  end

  byte_tx_reg u_tx (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_data (w_load_data),
    .i_ready(tx_ready),
    .o_data (tx_data),
    .o_valid(tx_valid),
    .o_xfer (w_xfer)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sample    <= '0;
      r_cnt       <= 16'h0000;
      r_csum      <= '0;
      r_frame_cnt <= 16'h0000;
    end else begin
      unique case (r_state)
        ST_IDLE: if (en) begin
          r_csum  <= '0;
          r_state <= ST_HDR;
        end
        ST_HDR:   if (w_xfer) r_state <= ST_FETCH;
        ST_FETCH: if (!empty) r_state <= ST_WAIT;
        ST_WAIT: begin
          r_sample <= q;
          r_state  <= ST_HI;
        end
        ST_HI: if (w_xfer) begin
          r_csum  <= r_csum ^ r_sample[15:8];
          r_state <= ST_LO;
        end
        ST_LO: if (w_xfer) begin
          r_csum  <= r_csum ^ r_sample[7:0];
          r_cnt   <= r_cnt + 16'd1;
          r_state <= w_last ? ST_CSUM : ST_FETCH;
        end
        ST_CSUM: if (w_xfer) begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
          r_cnt       <= 16'h0000;
          r_csum      <= '0;
          r_state     <= en ? ST_HDR : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pip_reader.sv
// Directed bench for pip_reader with FRAME_LEN=2, a small FIFO model and a
// byte collector on the tx handshake.
module tb_pip_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        empty;
  logic [15:0] q;
  logic        rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [15:0] frame_cnt;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] mem [0:31];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          rd_n = 0;
  int          pop_err = 0;
  logic [7:0]  rx [0:63];
  int          rx_n = 0;
  int          base;

  always #5 clk = ~clk;

  pip_reader #(.DATA_WIDTH(16), .FRAME_LEN(2), .SYNC(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .empty    (empty),
    .q        (q),
    .rd       (rd),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  assign empty = (wr_ptr == rd_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= 16'h0000;
      rd_ptr <= 0;
    end else if (rd) begin
      if (wr_ptr == rd_ptr) pop_err <= pop_err + 1;
      q      <= mem[rd_ptr % 32];
      rd_ptr <= rd_ptr + 1;
      rd_n   <= rd_n + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      rx[rx_n % 64] <= tx_data;
      rx_n          <= rx_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    mem[wr_ptr % 32] = v;
    wr_ptr++;
  endtask

  task automatic pulse_en();
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
  endtask

  task automatic wait_frame(input logic [15:0] target);
    int k = 0;
    while (frame_cnt !== target && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("frame_cnt", {16'h0, frame_cnt}, {16'h0, target});
  endtask

  task automatic wait_byte(input string tag, input logic [7:0] val);
    int k = 0;
    while (!(tx_valid === 1'b1 && tx_data === val) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(tag, {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, val});
  endtask

  task automatic wait_rx(input int n);
    int k = 0;
    while (rx_n < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("rx_count", rx_n, n);
  endtask

  task automatic check_bytes(input string tag, input int b, input logic [47:0] exp);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_b%0d", tag, i), {24'h0, rx[(b + i) % 64]}, {24'h0, exp[47 - 8*i -: 8]});
    check({tag, "_len"}, rx_n - b, 6);
  endtask

  initial begin
    logic held_ok;
    logic rd_seen;
    logic gap_ok;
    int   rd_base;

    rst      = 1'b1;
    en       = 1'b0;
    tx_ready = 1'b0;
    #1;
    check("rst_rd",       {31'h0, rd},       32'h0);
    check("rst_valid",    {31'h0, tx_valid}, 32'h0);
    check("rst_busy",     {31'h0, busy},     32'h0);
    check("rst_data",     {24'h0, tx_data},  32'h0);
    check("rst_frame",    {16'h0, frame_cnt}, 32'h0);
    @(negedge clk) rst = 1'b0;

    // Basic frame, en only pulsed: the frame still completes, then idle.
    push(16'h1234);
    push(16'hABCD);
    base     = rx_n;
    rd_base  = rd_n;
    tx_ready = 1'b1;
    pulse_en();
    wait_frame(16'd1);
    check_bytes("basic", base, 48'hA5_12_34_AB_CD_40);
    check("basic_idle", {31'h0, busy}, 32'h0);
    check("basic_pops", rd_n - rd_base, 2);

    // Backpressure on the first sample byte.
    push(16'h1234);
    push(16'hABCD);
    base = rx_n;
    pulse_en();
    wait_byte("bp_hi_seen", 8'h12);
    tx_ready = 1'b0;
    held_ok  = 1'b1;
    rd_seen  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!(tx_valid === 1'b1 && tx_data === 8'h12)) held_ok = 1'b0;
      if (rd !== 1'b0) rd_seen = 1'b1;
    end
    check("bp_held", {31'h0, held_ok}, 32'h1);
    check("bp_no_rd", {31'h0, rd_seen}, 32'h0);
    tx_ready = 1'b1;
    wait_frame(16'd2);
    check_bytes("bp", base, 48'hA5_12_34_AB_CD_40);

    // FIFO underflow between the two samples.
    push(16'h1234);
    base = rx_n;
    pulse_en();
    wait_rx(base + 3);
    gap_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd !== 1'b0 || tx_valid !== 1'b0) gap_ok = 1'b0;
    end
    check("uf_gap_quiet", {31'h0, gap_ok}, 32'h1);
    push(16'hABCD);
    wait_frame(16'd3);
    check_bytes("uf", base, 48'hA5_12_34_AB_CD_40);

    // Reset while the high byte is held, then a fresh frame with en held.
    push(16'h1111);
    @(negedge clk) en = 1'b1;
    wait_byte("mid_hi_seen", 8'h11);
    tx_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rd",    {31'h0, rd},        32'h0);
    check("mid_rst_valid", {31'h0, tx_valid},  32'h0);
    check("mid_rst_busy",  {31'h0, busy},      32'h0);
    check("mid_rst_data",  {24'h0, tx_data},   32'h0);
    check("mid_rst_frame", {16'h0, frame_cnt}, 32'h0);
    wr_ptr = 0;
    @(negedge clk);
    push(16'h5678);
    push(16'h9ABC);
    base     = rx_n;
    tx_ready = 1'b1;
    rst      = 1'b0;
    wait_frame(16'd1);
    check_bytes("post_rst", base, 48'hA5_56_78_9A_BC_08);
    check("b2b_busy",  {31'h0, busy}, 32'h1);
    check("b2b_sync",  {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hA5});
    check("pop_empty", pop_err, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
